// File: rtl/vote_round_ctrl.sv
// ---------------------------------------------------------------------------
// vote_round_ctrl
//
// Sequences one three-voter majority round:
//   IDLE   -> waits for start; keeps last round's voted/pass for display.
//   OPEN   -> vote window; latches each voter's first press (sticky bits).
//             Closes on timeout or as soon as all three have voted.
//             cancel aborts back to IDLE with the latches cleared.
//   TALLY  -> single cycle; computes 2-of-3 majority from the latches.
//   RESULT -> holds the result for HOLD_CYCLES, then returns to IDLE with
//             a one-cycle done pulse.
//
// Parameters:
//   WIN_CYCLES  : vote window length in clk cycles (>= 1)
//   HOLD_CYCLES : result hold length in clk cycles (>= 1)
//   CNT_W       : shared counter width; both lengths must fit
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   begin a round (accepted in IDLE only)
//   cancel       in   abort the round (effective in OPEN only)
//   vote_a/b/c   in   voter presses, already synchronised to clk
//   window_open  out  high while votes are accepted
//   voted[2:0]   out  sticky per-voter latch, {c,b,a}
//   pass         out  majority result (at least 2 of 3 voted)
//   result_valid out  high while the result is being held
//   done         out  one-cycle pulse on the first IDLE cycle after RESULT
// ---------------------------------------------------------------------------
module vote_round_ctrl #(
  parameter int WIN_CYCLES  = 1000,
  parameter int HOLD_CYCLES = 500,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cancel,
  input  logic       vote_a,
  input  logic       vote_b,
  input  logic       vote_c,
  output logic       window_open,
  output logic [2:0] voted,
  output logic       pass,
  output logic       result_valid,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_OPEN   = 2'd1,
    S_TALLY  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  // Terminal counts; the counter is compared for equality only and is
  // cleared on every state change, so it never needs to wrap.
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       voted_q;
  logic             pass_q;
  logic             window_open_q;
  logic             result_valid_q;
  logic             done_q;

  // Candidate latch value including this cycle's presses. Used both to
  // update the latch and to detect an early close, so votes arriving on
  // the closing cycle are never lost.
  logic [2:0] votes_in;
  logic [2:0] voted_d;
  logic       all_voted_d;
  logic       win_timeout;
  logic       hold_expired;
  logic       pass_d;

  assign votes_in     = {vote_c, vote_b, vote_a};
  assign voted_d      = voted_q | votes_in;
  assign all_voted_d  = &voted_d;
  assign win_timeout  = (cnt_q == WIN_LAST);
  assign hold_expired = (cnt_q == HOLD_LAST);

  // 2-of-3 majority of the frozen latches.
  assign pass_d = (voted_q[0] & voted_q[1]) |
                  (voted_q[0] & voted_q[2]) |
                  (voted_q[1] & voted_q[2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      voted_q        <= '0;
      pass_q         <= 1'b0;
      window_open_q  <= 1'b0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // done is only ever high for the first IDLE cycle.
          done_q <= 1'b0;
          // cancel is meaningless here, so start always wins.
          if (start) begin
            state_q       <= S_OPEN;
            window_open_q <= 1'b1;
            voted_q       <= '0;
            pass_q        <= 1'b0;
            cnt_q         <= '0;
          end
        end

        S_OPEN: begin
          if (cancel) begin
            // Abort beats both close conditions; no done pulse.
            state_q       <= S_IDLE;
            window_open_q <= 1'b0;
            voted_q       <= '0;
            cnt_q         <= '0;
          end else begin
            voted_q <= voted_d;
            if (win_timeout || all_voted_d) begin
              state_q       <= S_TALLY;
              window_open_q <= 1'b0;
              cnt_q         <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        S_TALLY: begin
          pass_q         <= pass_d;
          state_q        <= S_RESULT;
          result_valid_q <= 1'b1;
          cnt_q          <= '0;
        end

        S_RESULT: begin
          if (hold_expired) begin
            state_q        <= S_IDLE;
            result_valid_q <= 1'b0;
            done_q         <= 1'b1;
            cnt_q          <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q        <= S_IDLE;
          cnt_q          <= '0;
          window_open_q  <= 1'b0;
          result_valid_q <= 1'b0;
          done_q         <= 1'b0;
        end
      endcase
    end
  end

  assign window_open  = window_open_q;
  assign voted        = voted_q;
  assign pass         = pass_q;
  assign result_valid = result_valid_q;
  assign done         = done_q;

endmodule
